// File: rtl/serial_sub_4bit_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and default width.
package serial_sub_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_4bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit needs to borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_4bit.sv
// Bit-serial unsigned subtractor: A - B computed LSB first, one bit per clock,
// with a start/busy/done handshake and a registered borrow chain.
module serial_sub_4bit
  import serial_sub_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [WIDTH:0]   ans,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: start is accepted only in IDLE or DONE; busy is high while bits
  // are processed; done is a one-cycle pulse marking diff/borrow/ans valid.
  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   diff_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bq_q;
  logic               borrow_q;
  logic               busy_q;
  logic               done_q;

  logic               bit_d;
  logic               bout_d;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bq_q),
    .d    (bit_d),
    .bout (bout_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      cnt_q     <= '0;
      bq_q      <= 1'b0;
      borrow_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            bq_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Each difference bit enters at the MSB so the first bit lands in bit 0.
          diff_sh_q <= {bit_d, diff_sh_q[WIDTH-1:1]};
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          bq_q      <= bout_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            borrow_q <= bout_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign diff        = diff_sh_q;
  assign borrow      = borrow_q;
  assign ans         = {borrow_q, diff_sh_q};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_sub_4bit.sv
// Directed bench for serial_sub_4bit: handshake timing, corners, back-to-back,
// mid-operation reset and all 256 operand pairs.
module tb_serial_sub_4bit;
  import serial_sub_4bit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;
  logic [4:0] ans;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  // Clock/reset block
  always #5 clk = ~clk;

  serial_sub_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .diff        (diff),
    .borrow      (borrow),
    .ans         (ans),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Called at the first negedge after an accepting edge; returns the cycle index of done.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Driver: one start pulse, then scoreboard the result and busy length.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp, input int gap);
    int         busy_cnt;
    bit         seen;
    logic [4:0] e;
    exp_q.push_back(exp);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 4'($urandom_range(0, 15));
    b_in  = 4'($urandom_range(0, 15));
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check(tag, "done_seen", 32'(seen), 32'd1);
    check(tag, "busy_cycles", 32'(busy_cnt), 32'd4);
    check(tag, "busy_at_done", 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check(tag, "ans", 32'(ans), 32'(e));
    check(tag, "diff", 32'(diff), 32'(e[3:0]));
    check(tag, "borrow", 32'(borrow), 32'(e[4]));
    @(negedge clk);
    check(tag, "done_pulse_len", 32'(done), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin : stim
    int         n;
    int         done_hits;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [4:0] m;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("reset", "busy", 32'(busy), 32'd0);
    check("reset", "done", 32'(done), 32'd0);
    check("reset", "ans", 32'(ans), 32'd0);
    check("reset", "state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and negative results
    run_op("t1_9m3", 4'd9, 4'd3, 5'b00110, 1);
    run_op("t2_3m9", 4'd3, 4'd9, 5'b11010, 0);
    run_op("t2_0m15", 4'd0, 4'd15, 5'b10001, 2);
    check("hold", "ans_idle", 32'(ans), 32'h11);

    // Corners
    run_op("t3_15m15", 4'd15, 4'd15, 5'b00000, 1);
    run_op("t3_15m0", 4'd15, 4'd0, 5'b01111, 1);
    run_op("t3_0m0", 4'd0, 4'd0, 5'b00000, 1);

    // Back-to-back with start held high
    a_in  = 4'd7;
    b_in  = 4'd2;
    start = 1'b1;
    @(negedge clk);
    wait_done(n);
    check("t4_b2b_a", "done_cycle", 32'(n), 32'd5);
    check("t4_b2b_a", "ans", 32'(ans), 32'h05);
    a_in = 4'd2;
    b_in = 4'd7;
    @(negedge clk);
    check("t4_b2b_b", "busy_restart", 32'(busy), 32'd1);
    wait_done(n);
    check("t4_b2b_b", "done_cycle", 32'(n), 32'd5);
    check("t4_b2b_b", "ans", 32'(ans), 32'h1B);
    start = 1'b0;
    @(negedge clk);
    check("t4_b2b_end", "done", 32'(done), 32'd0);
    check("t4_b2b_end", "state", 32'(dbg_state), 32'(ST_IDLE));

    // Start during RUN is ignored
    a_in  = 4'd7;
    b_in  = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in  = 4'd1;
    b_in  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("t4_ign", "done_cycle", 32'(n), 32'd3);
    check("t4_ign", "ans", 32'(ans), 32'h05);
    @(negedge clk);
    check("t4_ign", "busy_after", 32'(busy), 32'd0);
    check("t4_ign", "ans_hold", 32'(ans), 32'h05);

    // Reset in the middle of an operation
    a_in  = 4'd12;
    b_in  = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_rst", "busy_c2", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst", "busy", 32'(busy), 32'd0);
    check("t5_rst", "done", 32'(done), 32'd0);
    check("t5_rst", "diff", 32'(diff), 32'd0);
    check("t5_rst", "borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    done_hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_hits++;
    end
    check("t5_rst", "no_activity", 32'(done_hits), 32'd0);
    run_op("t5_fresh", 4'd12, 4'd5, 5'b00111, 1);

    // Exhaustive pairs with random idle gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ea = 4'(a);
        eb = 4'(b);
        m  = 5'($signed({1'b0, ea}) - $signed({1'b0, eb}));
        run_op("t6_exh", ea, eb, m, int'($urandom_range(0, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_4bit.md
Name: serial_sub_4bit

Overview:
Bit-serial unsigned subtractor, the counterpart of the team's ripple 4-bit adder. It computes A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. The result is a WIDTH-bit difference plus a borrow-out. {borrow, diff} read as a (WIDTH+1)-bit two's-complement value equals A − B. Used in the arithmetic hands-on chapters as the first sequential datapath with a start/busy/done handshake.

Parameters:
WIDTH, 4, operand and difference width in bits; legal range 2..16.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
clk     input   1           rising-edge clock
rst_n   input   1           synchronous reset, active-low
start   input   1           request; sampled only in IDLE or DONE
A       input   WIDTH       minuend, unsigned; captured on accepted start
B       input   WIDTH       subtrahend, unsigned; captured on accepted start
busy    output  1           high while bits are being processed
done    output  1           one-cycle pulse when the result is valid
diff    output  WIDTH       A − B mod 2^WIDTH
borrow  output  1           1 when A < B
ans     output  WIDTH+1     {borrow, diff}; signed result of A − B

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled low at a rising clk edge). All outputs go to 0 (busy, done, diff, borrow, ans). Operand registers, counter and borrow flop are cleared. FSM goes to IDLE.
- Reset mid-operation: abort immediately. No done pulse. The partial result is discarded and the outputs read 0.
- FSM states:
  - IDLE: start=1 → capture A into a_sh and B into b_sh, clear borrow flop and cnt → RUN.
  - RUN: busy=1 each cycle.
    - d = a_sh[0] ^ b_sh[0] ^ bq
    - bo = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bq)
    - d shifts into the MSB of the diff shift register; a_sh and b_sh shift right; bq <= bo; cnt++.
    - When cnt == WIDTH−1 → DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; diff and borrow are final.
    - start=1 → accept new operands, go to RUN (back-to-back).
    - Otherwise → IDLE.
- Latency: start accepted at edge N. busy is high for edges N+1..N+WIDTH. done is high in the cycle after edge N+WIDTH (WIDTH+1 cycles from start to done). Throughput: one operation per WIDTH+1 cycles when back-to-back.
- Output hold: diff, borrow and ans keep the last result from DONE through IDLE until the next operation completes.
  - While RUN, diff shows the shift register in progress and is not valid.
  - borrow updates only on entry to DONE.
- start during RUN is ignored; it is not queued.
- A and B may change freely after the accepting edge.
- Width rules: no internal truncation except the defined mod-2^WIDTH difference. borrow = 1 iff A < B. A == B gives diff = 0, borrow = 0.

Decomposition:
- Shared package/header: FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the default WIDTH constant, so a later serial adder and multiplier reuse them.
- One natural sub-module, full_subtractor: inputs a, b, bin; outputs d, bout. Purely combinational, instantiated once in the datapath. It is the mirror cell of the existing full adder.

Test Plan:
1. Reset, then A=9, B=3, start pulse → after 5 cycles done=1, diff=4'b0110, borrow=0, ans=5'b00110 (+6).
2. A=3, B=9 → diff=4'b1010, borrow=1, ans=5'b11010 (−6). Also A=0, B=15 → diff=4'b0001, borrow=1, ans=5'b10001 (−15).
3. Corners: A=15, B=15 → diff=0, borrow=0. A=15, B=0 → diff=15, borrow=0. A=0, B=0 → 0, 0.
4. Hold start high continuously with new operands each DONE (7−2, then 2−7) → done every 5th cycle, results 5/0 then 11/1. Start pulses during RUN are ignored and leave the result unchanged.
5. Start 12−5, then drive rst_n low at the 2nd busy cycle → next edge: busy=0, done=0, diff=0, borrow=0. No done pulse follows. A fresh 12−5 afterwards gives 7/0.
6. Exhaustive: all 256 A,B pairs with random idle gaps → ans matches $signed({1'b0,A}) − $signed({1'b0,B}). busy is high exactly 4 cycles per operation.
